// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch widths and constants, plus the layout of one prefetch-queue entry.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush and active-low reset.
// A push while full is taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
  always_comb begin
    rd_d = rd_q + AW'(do_pop);
    wr_d = wr_q + AW'(do_push);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: credit-limited instruction prefetcher; requests are tagged with their pc in order,
// and responses still owed to requests issued before a redirect are counted off and dropped.
module instr_prefetch
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fpc_q, fpc_d, tag;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, q_cnt, tag_cnt;
  logic accept, discard, keep, pop;
  fetch_entry_t head;
  // queue slots plus in-flight requests never exceed DEPTH, so a response always has room
  assign imem_req_valid = reset && (q_cnt + outst_q) < CW'(DEPTH);
  assign imem_req_addr = fpc_q;
  assign accept = imem_req_valid && imem_req_ready;
  assign discard = imem_rsp_valid && drop_q != '0;
  assign keep = imem_rsp_valid && !discard && !branch_taken && tag_cnt != '0;
  assign out_valid = reset && q_cnt != '0;
  assign pop = out_valid && out_ready && !branch_taken;
  assign out_pc = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : (reset ? NOP : '0);
  always_comb begin
    fpc_d = branch_taken ? (branch_target & ~32'h3) : fpc_q + (accept ? PC_INC : '0);
    outst_d = outst_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d = branch_taken ? outst_d : drop_q - CW'(discard);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_q <= RESET_PC;
      outst_q <= '0;
      drop_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
    end
  end
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (branch_taken),
    .push_i  (accept && !branch_taken),
    .wdata_i (fpc_q),
    .pop_i   (keep),
    .rdata_o (tag),
    .count_o (tag_cnt)
  );
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (branch_taken),
    .push_i  (keep),
    .wdata_i ({tag, imem_rsp_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (q_cnt)
  );
endmodule
